// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between the execute stage and seq_divider
//
// Ports (master = core side, slave = divider side):
//   start  core -> div  request a division (sampled only while idle)
//   sgn    core -> div  1 = signed floored division, 0 = unsigned
//   x      core -> div  dividend, valid in the start cycle only
//   y      core -> div  divisor, valid in the start cycle only
//   busy   div -> core  division in progress, stalls the core
//   done   div -> core  one-cycle pulse, quot/rem/dz valid
//   quot   div -> core  quotient
//   rem    div -> core  remainder
//   dz     div -> core  divide-by-zero flag of the last completed division
interface seq_divider_if #(
  parameter int W = 32
);
  logic         start;
  logic         sgn;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         dz;

  modport master (
    output start, sgn, x, y,
    input  busy, done, quot, rem, dz
  );

  modport slave (
    input  start, sgn, x, y,
    output busy, done, quot, rem, dz
  );
endinterface

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider, unsigned and signed floored
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  synchronous reset, active low
//   bus  seq_divider_if slave: start/sgn/x/y in, busy/done/quot/rem/dz out
//
// One quotient bit per cycle on operand magnitudes; sign correction is applied
// in a single FIX cycle. Latency from the start edge to done is W+1 cycles.
module seq_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          sgn_r;
  logic          xneg;
  logic          yneg;
  logic          yzero;
  logic [W-1:0]  xraw;
  logic [W-1:0]  ym;
  // Dividend magnitude shifts out at the top while quotient bits shift in at
  // the bottom, so after W iterations this register holds the magnitude quotient.
  logic [W-1:0]  dq;
  logic [W:0]    pr;

  logic [W-1:0]  abs_x;
  logic [W-1:0]  abs_y;
  logic [W+1:0]  shifted;
  logic [W+1:0]  diff;
  logic          fits;
  logic [W:0]    pr_next;
  logic [W-1:0]  rm;
  logic [W-1:0]  fix_quot;
  logic [W-1:0]  fix_rem;

  always_comb begin
    abs_x = (bus.sgn && bus.x[W-1]) ? -bus.x : bus.x;
    abs_y = (bus.sgn && bus.y[W-1]) ? -bus.y : bus.y;
  end

  // Restoring step: bring in the next dividend bit and trial-subtract |y|.
  // A clear borrow bit means the divisor fits and the difference is kept.
  always_comb begin
    shifted = {pr, dq[W-1]};
    diff    = shifted - {2'b00, ym};
    fits    = ~diff[W+1];
    pr_next = fits ? diff[W:0] : shifted[W:0];
  end

  // Floored-division sign fix-up. When signs differ and the remainder is
  // non-zero, the quotient rounds down one more (-qm-1 == ~qm) and the
  // remainder becomes |y|-rm carrying the sign of y.
  always_comb begin
    rm       = pr[W-1:0];
    fix_quot = dq;
    fix_rem  = rm;
    if (yzero) begin
      fix_quot = '1;
      fix_rem  = xraw;
    end else if (sgn_r) begin
      if (xneg == yneg) begin
        fix_rem = yneg ? -rm : rm;
      end else if (rm == '0) begin
        fix_quot = -dq;
        fix_rem  = '0;
      end else begin
        fix_quot = ~dq;
        fix_rem  = yneg ? -(ym - rm) : (ym - rm);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sgn_r    <= 1'b0;
      xneg     <= 1'b0;
      yneg     <= 1'b0;
      yzero    <= 1'b0;
      xraw     <= '0;
      ym       <= '0;
      dq       <= '0;
      pr       <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quot <= '0;
      bus.rem  <= '0;
      bus.dz   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sgn_r    <= bus.sgn;
            xneg     <= bus.sgn & bus.x[W-1];
            yneg     <= bus.sgn & bus.y[W-1];
            yzero    <= (bus.y == '0);
            xraw     <= bus.x;
            dq       <= abs_x;
            ym       <= abs_y;
            pr       <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          pr  <= pr_next;
          dq  <= {dq[W-2:0], fits};
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          bus.quot <= fix_quot;
          bus.rem  <= fix_rem;
          bus.dz   <= yzero;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle integer divider for the RISC5 execute stage. It takes its two operands directly from the register file read ports and returns quotient and remainder for write-back through the register file write port. It stalls the core while busy. Unsigned division and signed (floored) division are both supported. A fixed-latency restoring algorithm produces one quotient bit per cycle.

## Interface
- W, 32, operand and result width in bits (W ≥ 2)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  request a division; sampled only in IDLE
- sgn  in  1  1 = signed floored division, 0 = unsigned; sampled with start
- x  in  W  dividend, from register file read port
- y  in  W  divisor, from register file read port
- busy  out  1  high while a division is in progress; core stall source
- done  out  1  one-cycle pulse when quot/rem/dz become valid
- quot  out  W  quotient
- rem  out  W  remainder
- dz  out  1  divide-by-zero flag for the last completed division

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - On start=1, latch sgn, sign(x), sign(y), |x| and |y|. In signed mode the magnitudes are two's-complement abs; in unsigned mode they are the raw values.
  - Clear the partial remainder and cycle counter, then go to RUN.
  - With start=0, remain in IDLE.
- RUN:
  - Perform W restoring iterations, MSB first.
  - Each iteration shifts the next dividend bit into a (W+1)-bit partial remainder, trial-subtracts |y|, and shifts the quotient bit in.
  - After counter reaches W−1, go to FIX.
- FIX:
  - Apply sign rules, register quot/rem/dz, pulse done, return to IDLE.
- Result rules, with qm and rm the magnitude quotient and remainder:
  - Unsigned: quot=qm, rem=rm.
  - Signed, sign(x)=sign(y): quot=qm. rem=rm if y>0, −rm if y<0.
  - Signed, signs differ, rm=0: quot=−qm, rem=0.
  - Signed, signs differ, rm≠0: quot=−qm−1. rem=|y|−rm if y>0, −(|y|−rm) if y<0.
  - Net effect: quot=floor(x/y), rem has the sign of y, and |rem|<|y|.
  - All arithmetic is modulo 2^W. Signed x=−2^(W−1), y=−1 gives quot=0x8000_0000 (wrap), rem=0. No overflow flag.
- Divide by zero (y=0, either mode):
  - quot=all ones, rem=x (raw), dz=1.
  - Latency is the same as a normal division.
  - For every non-zero divisor, dz=0.
- quot, rem and dz hold their value until the next FIX or reset.
- start while busy=1 is ignored; sgn, x and y changes while busy have no effect.

## Timing
- Reset (rst=0 at an edge):
  - state=IDLE, busy=0, done=0, quot=0, rem=0, dz=0, counter=0.
  - Reset has priority over everything. Reset mid-RUN aborts the division with no done pulse.
- Latency: start is sampled at edge E0.
  - RUN occupies edges E1..EW.
  - FIX is at edge E(W+1).
- busy is registered: high in the W+1 cycles following E0..EW, low after E(W+1).
- done is high only in the cycle following E(W+1), with quot/rem/dz valid in that cycle. For W=32, done is seen 33 cycles after the start edge.
- Back-to-back operation:
  - start may be high in the same cycle done is high, since state is IDLE.
  - The new operation begins at that edge with no idle gap. Throughput is one division per W+1 cycles.
- The core must hold x/y valid only in the start cycle.

## Test plan
- Reset, then unsigned x=7, y=2, start one cycle. Required:
  - busy high for exactly 33 cycles.
  - done pulse in cycle 33 after the start edge.
  - quot=3, rem=1, dz=0.
- Signed cases:
  - x=−7 (0xFFFF_FFF9), y=2: quot=0xFFFF_FFFC (−4), rem=1.
  - x=7, y=−2: quot=0xFFFF_FFFC, rem=0xFFFF_FFFF (−1).
  - x=−7, y=−2: quot=3, rem=0xFFFF_FFFF.
  - x=−8, y=2: quot=−4, rem=0.
- Divide by zero, x=0x1234_5678, y=0, in both modes: quot=0xFFFF_FFFF, rem=0x1234_5678, dz=1, same 33-cycle latency. A following 10/3 clears dz (quot=3, rem=1).
- Edge cases:
  - Signed 0x8000_0000 / 0xFFFF_FFFF: quot=0x8000_0000, rem=0.
  - Unsigned 0xFFFF_FFFF / 1: quot=0xFFFF_FFFF, rem=0.
  - Unsigned 5 / 0xFFFF_FFFF: quot=0, rem=5.
- Busy-time start and back-to-back:
  - start pulsed again mid-RUN with new operands: ignored, and the first result is unchanged.
  - start asserted during the done cycle: second division completes exactly 33 cycles later.
- rst=0 at cycle 10 of a division: all outputs 0 next cycle, no done pulse. A new start after release completes normally.
- Randomized cross-check against a floor-division reference model: 10k random operand pairs per mode.
